mii_rx_framer: RTL

MII_RX_FRAMER -- requirements
Module: mii_rx_framer

---
 rtl/mii_rx_framer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/mii_rx_framer.sv
// mii_rx_framer: assembles MII/RMII receive beats into bytes, strips the
// preamble/SFD, checks FCS and length, and reports per-frame status and
// running good/bad frame counts.
module mii_rx_framer #(
    parameter int DATA_W    = 4,
    parameter int MIN_FRAME = 64,
    parameter int MAX_FRAME = 1518,
    parameter int CNT_W     = 32
) (
    input  logic              enet_rx_clk,
    input  logic              i_reset,
    input  logic              i_rx_dv,
    input  logic              i_rx_er,
    input  logic [DATA_W-1:0] i_rx_data,
    output logic [7:0]        o_byte,
    output logic              o_byte_valid,
    output logic              o_sof,
    output logic              o_eof,
    output logic              o_frame_ok,
    output logic [4:0]        o_status,
    output logic [15:0]       o_last_len,
    output logic [CNT_W-1:0]  o_good_frames,
    output logic [CNT_W-1:0]  o_bad_frames
);

    localparam int          BEATS   = 8 / DATA_W;
    localparam int          IDX_W   = $clog2(BEATS);
    localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME);
    localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME);
    localparam logic [31:0] POLY    = 32'hEDB88320;  // 0x04C11DB7 reflected
    localparam logic [31:0] RESIDUE = 32'hC704DD7B;  // MSB-first view of a good-frame register

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

    state_t                  state, nxt_state;
    logic [IDX_W-1:0]        beat_idx;
    logic [8-DATA_W-1:0]     part;        // earlier beats of the byte in flight
    logic [7:0]              cur_byte;    // byte as it stands with this beat added
    logic                    last_beat;
    logic                    seen_55;
    logic                    first_cyc;   // first clock after reset release
    logic [31:0]             crc;
    logic [15:0]             byte_cnt;
    logic                    er_seen;
    logic                    fcs_bad;
    logic [4:0]              status_nxt;
    logic                    frame_init, byte_done, end_frame, saw_55;

    // LSB-first reflected CRC-32 update, one byte
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = {1'b0, r[31:1]} ^ POLY;
            else             r = {1'b0, r[31:1]};
        end
        return r;
    endfunction

    function automatic logic [31:0] rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    // New beats enter at the top and earlier ones slide down, so beat k lands in bits [k*DATA_W +: DATA_W]
    assign cur_byte   = {i_rx_data, part};
    assign last_beat  = (beat_idx == IDX_W'(BEATS - 1));
    assign fcs_bad    = (rev32(crc) != RESIDUE);
    assign status_nxt = {beat_idx != '0, er_seen | i_rx_er,
                         byte_cnt > MAX_LEN, byte_cnt < MIN_LEN, fcs_bad};

    // State register
    always_ff @(posedge enet_rx_clk) begin
        if (i_reset) state <= IDLE;
        else         state <= nxt_state;
    end

    // Next-state logic
    always_comb begin
        nxt_state = state;
        case (state)
            IDLE: begin
                if (i_rx_dv) nxt_state = first_cyc ? DROP : PREAMBLE;
            end
            PREAMBLE: begin
                if (!i_rx_dv)      nxt_state = IDLE;
                else if (i_rx_er)  nxt_state = DROP;
                else if (last_beat) begin
                    if (cur_byte == 8'h55)                nxt_state = PREAMBLE;
                    else if (cur_byte == 8'hD5 && seen_55) nxt_state = DATA;
                    else                                   nxt_state = DROP;
                end
            end
            DATA:    if (!i_rx_dv) nxt_state = IDLE;
            DROP:    if (!i_rx_dv) nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    // Per-state actions driving the datapath
    always_comb begin
        frame_init = 1'b0;
        byte_done  = 1'b0;
        end_frame  = 1'b0;
        saw_55     = 1'b0;
        case (state)
            PREAMBLE: begin
                frame_init = 1'b1;
                saw_55     = i_rx_dv && !i_rx_er && last_beat && (cur_byte == 8'h55);
            end
            DATA: begin
                byte_done = i_rx_dv && last_beat;
                end_frame = !i_rx_dv;
            end
            default: ;
        endcase
    end

    // Beat assembly, CRC/length tracking, byte output and end-of-frame report
    always_ff @(posedge enet_rx_clk) begin
        if (i_reset) begin
            first_cyc     <= 1'b1;
            beat_idx      <= '0;
            part          <= '0;
            seen_55       <= 1'b0;
            crc           <= '1;
            byte_cnt      <= '0;
            er_seen       <= 1'b0;
            o_byte        <= '0;
            o_byte_valid  <= 1'b0;
            o_sof         <= 1'b0;
            o_eof         <= 1'b0;
            o_frame_ok    <= 1'b0;
            o_status      <= '0;
            o_last_len    <= '0;
            o_good_frames <= '0;
            o_bad_frames  <= '0;
        end else begin
            first_cyc    <= 1'b0;
            o_byte_valid <= 1'b0;
            o_sof        <= 1'b0;
            o_eof        <= 1'b0;

            // Beat index restarts at the first valid beat seen from IDLE
            if (state == IDLE)  beat_idx <= i_rx_dv ? IDX_W'(1) : '0;
            else if (i_rx_dv)   beat_idx <= beat_idx + IDX_W'(1);
            if (i_rx_dv)        part <= cur_byte[7:DATA_W];

            if (state == IDLE)  seen_55 <= 1'b0;
            else if (saw_55)    seen_55 <= 1'b1;

            if (frame_init) begin
                crc      <= '1;
                byte_cnt <= '0;
                er_seen  <= 1'b0;
            end

            if (state == DATA && i_rx_dv && i_rx_er) er_seen <= 1'b1;

            // Bytes past MAX_FRAME are still counted and checked, just not presented
            if (byte_done) begin
                crc <= crc_byte(crc, cur_byte);
                if (byte_cnt != 16'hFFFF) byte_cnt <= byte_cnt + 16'd1;
                if (byte_cnt < MAX_LEN) begin
                    o_byte       <= cur_byte;
                    o_byte_valid <= 1'b1;
                    o_sof        <= (byte_cnt == 16'd0);
                end
            end

            if (end_frame) begin
                o_eof      <= 1'b1;
                o_status   <= status_nxt;
                o_frame_ok <= (status_nxt == 5'd0);
                o_last_len <= byte_cnt;
                if (status_nxt == 5'd0) o_good_frames <= o_good_frames + CNT_W'(1);
                else                    o_bad_frames  <= o_bad_frames + CNT_W'(1);
            end
        end
    end

endmodule
